// File: rtl/branch_predict_unit_if.sv
// Decode lookup / execute resolution bundle between the pipeline (master) and the predictor (slave).
interface branch_predict_unit_if #(
  parameter int BP_ADDR_BITS = 12
);
  logic                    D_valid_i;
  logic                    D_stall_i;
  logic                    D_flush_i;
  logic [31:0]             D_PC_i;
  logic                    D_isBranch_i;
  logic                    D_isJAL_i;
  logic                    D_isJALR_i;
  logic [4:0]              D_rdId_i;
  logic [4:0]              D_rs1Id_i;
  logic [31:0]             D_Jimm_i;
  logic [31:0]             D_Bimm_i;
  logic                    E_update_i;
  logic [BP_ADDR_BITS-1:0] E_bhtIndex_i;
  logic                    E_takeBranch_i;
  logic                    E_mispredict_i;
  logic                    ready_o;
  logic                    D_predictPC_o;
  logic [31:0]             D_PCprediction_o;
  logic                    D_predictBranch_o;
  logic [BP_ADDR_BITS-1:0] D_bhtIndex_o;
  logic [31:0]             D_predictRA_o;
  logic                    D_rasEmpty_o;
  logic [31:0]             mispredictCount_o;

  modport master (
    output D_valid_i, D_stall_i, D_flush_i, D_PC_i, D_isBranch_i, D_isJAL_i, D_isJALR_i,
           D_rdId_i, D_rs1Id_i, D_Jimm_i, D_Bimm_i,
           E_update_i, E_bhtIndex_i, E_takeBranch_i, E_mispredict_i,
    input  ready_o, D_predictPC_o, D_PCprediction_o, D_predictBranch_o, D_bhtIndex_o,
           D_predictRA_o, D_rasEmpty_o, mispredictCount_o
  );

  modport slave (
    input  D_valid_i, D_stall_i, D_flush_i, D_PC_i, D_isBranch_i, D_isJAL_i, D_isJALR_i,
           D_rdId_i, D_rs1Id_i, D_Jimm_i, D_Bimm_i,
           E_update_i, E_bhtIndex_i, E_takeBranch_i, E_mispredict_i,
    output ready_o, D_predictPC_o, D_PCprediction_o, D_predictBranch_o, D_bhtIndex_o,
           D_predictRA_o, D_rasEmpty_o, mispredictCount_o
  );
endinterface

// File: rtl/branch_predict_unit.sv
// Bimodal/gshare BHT plus circular return stack; answers decode combinationally (zero latency).
// Updates commit on the next rising edge; no backpressure, decode stall/flush only suppresses RAS ops.
module branch_predict_unit #(
  parameter int BP_ADDR_BITS = 12,
  parameter int BH_BITS      = 9,
  parameter int CTR_BITS     = 2,
  parameter int RAS_DEPTH    = 4,
  parameter int USE_GSHARE   = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  branch_predict_unit_if.slave  bp
);
  localparam int BHT_SIZE     = 1 << BP_ADDR_BITS;
  localparam int RAS_PTR_BITS = $clog2(RAS_DEPTH);
  localparam logic [CTR_BITS-1:0]   CTR_INIT = CTR_BITS'((1 << (CTR_BITS-1)) - 1);
  localparam logic [RAS_PTR_BITS:0] RAS_FULL = (RAS_PTR_BITS+1)'(RAS_DEPTH);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic [BP_ADDR_BITS-1:0] sweep_idx_q, sweep_idx_d;
  logic [BH_BITS-1:0]      hist_q, hist_d;
  logic [31:0]             mcnt_q, mcnt_d;
  logic [RAS_PTR_BITS-1:0] tp_q, tp_d;
  logic [RAS_PTR_BITS:0]   cnt_q, cnt_d;

  logic [CTR_BITS-1:0] bht_q [BHT_SIZE];
  logic [31:0]         ras_q [RAS_DEPTH];

  logic [BP_ADDR_BITS-1:0] pc_idx, lookup_idx, bht_wa;
  logic [CTR_BITS-1:0]     lookup_ctr, upd_ctr, bht_wd;
  logic                    bht_we;
  logic                    predict_branch;
  logic [31:0]             pc_plus4, ras_top;

  // ---------------- lookup ----------------
  assign pc_idx = bp.D_PC_i[BP_ADDR_BITS+1:2];

  generate
    if (USE_GSHARE != 0) begin : g_gshare
      assign lookup_idx = pc_idx ^ (BP_ADDR_BITS'(hist_q) << (BP_ADDR_BITS - BH_BITS));
    end else begin : g_bimodal
      assign lookup_idx = pc_idx;
    end
  endgenerate

  assign lookup_ctr     = bht_q[lookup_idx];
  assign predict_branch = ready_q & lookup_ctr[CTR_BITS-1];
  assign pc_plus4       = bp.D_PC_i + 32'd4;
  assign ras_top        = ras_q[tp_q];

  logic rd_link, rs1_link, pred_taken;
  logic [31:0] pred_target;

  assign rd_link  = (bp.D_rdId_i == 5'd1)  || (bp.D_rdId_i == 5'd5);
  assign rs1_link = (bp.D_rs1Id_i == 5'd1) || (bp.D_rs1Id_i == 5'd5);

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = bp.D_PC_i + bp.D_Bimm_i;
    if (bp.D_isJAL_i) begin
      pred_taken  = 1'b1;
      pred_target = bp.D_PC_i + bp.D_Jimm_i;
    end else if (bp.D_isJALR_i) begin
      pred_taken  = rs1_link && (cnt_q != '0);
      pred_target = ras_top;
    end else if (bp.D_isBranch_i) begin
      pred_taken  = predict_branch;
    end
  end

  assign bp.ready_o           = ready_q;
  assign bp.D_predictPC_o     = bp.D_valid_i & pred_taken;
  assign bp.D_PCprediction_o  = pred_target;
  assign bp.D_predictBranch_o = predict_branch;
  assign bp.D_bhtIndex_o      = lookup_idx;
  assign bp.D_predictRA_o     = ras_top;
  assign bp.D_rasEmpty_o      = (cnt_q == '0);
  assign bp.mispredictCount_o = mcnt_q;

  // ---------------- return stack control ----------------
  logic ras_fire, do_push, do_pop, do_pp, ras_we;
  logic [RAS_PTR_BITS-1:0] ras_wa;

  assign ras_fire = bp.D_valid_i && !bp.D_stall_i && !bp.D_flush_i;

  always_comb begin
    do_push = 1'b0;
    do_pop  = 1'b0;
    do_pp   = 1'b0;
    if (ras_fire) begin
      if (bp.D_isJAL_i) begin
        do_push = rd_link;
      end else if (bp.D_isJALR_i) begin
        do_push = rd_link && (!rs1_link || (bp.D_rdId_i == bp.D_rs1Id_i));
        do_pop  = !rd_link && rs1_link;
        do_pp   = rd_link && rs1_link && (bp.D_rdId_i != bp.D_rs1Id_i);
      end
    end
  end

  always_comb begin
    tp_d   = tp_q;
    cnt_d  = cnt_q;
    ras_we = 1'b0;
    ras_wa = tp_q;
    if (do_push) begin
      tp_d   = tp_q + 1'b1;
      ras_we = 1'b1;
      ras_wa = tp_q + 1'b1;
      cnt_d  = (cnt_q == RAS_FULL) ? cnt_q : cnt_q + 1'b1;
    end else if (do_pop) begin
      if (cnt_q != '0) begin
        tp_d  = tp_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end else if (do_pp) begin
      // Return-and-call in one instruction: replace the top in place.
      ras_we = 1'b1;
      cnt_d  = (cnt_q == '0) ? (RAS_PTR_BITS+1)'(1) : cnt_q;
    end
  end

  // ---------------- BHT sweep / update ----------------
  assign upd_ctr = bht_q[bp.E_bhtIndex_i];

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    sweep_idx_d = sweep_idx_q;
    hist_d      = hist_q;
    mcnt_d      = mcnt_q + (bp.E_mispredict_i ? 32'd1 : 32'd0);
    bht_we      = 1'b0;
    bht_wa      = bp.E_bhtIndex_i;
    bht_wd      = upd_ctr;
    if (state_q == ST_INIT) begin
      bht_we      = 1'b1;
      bht_wa      = sweep_idx_q;
      bht_wd      = CTR_INIT;
      sweep_idx_d = sweep_idx_q + 1'b1;
      if (sweep_idx_q == '1) begin
        state_d = ST_READY;
        ready_d = 1'b1;
      end
    end else if (bp.E_update_i) begin
      bht_we = 1'b1;
      if (bp.E_takeBranch_i) bht_wd = (upd_ctr == '1) ? upd_ctr : upd_ctr + 1'b1;
      else                   bht_wd = (upd_ctr == '0) ? upd_ctr : upd_ctr - 1'b1;
      hist_d = BH_BITS'({bp.E_takeBranch_i, hist_q} >> 1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q     <= ST_INIT;
      ready_q     <= 1'b0;
      sweep_idx_q <= '0;
      hist_q      <= '0;
      mcnt_q      <= '0;
      tp_q        <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      sweep_idx_q <= sweep_idx_d;
      hist_q      <= hist_d;
      mcnt_q      <= mcnt_d;
      tp_q        <= tp_d;
      cnt_q       <= cnt_d;
    end
  end

  // Storage arrays are not reset; the sweep clears the BHT and cnt gates RAS reads.
  always_ff @(posedge clk_i) begin
    if (reset_i && bht_we) bht_q[bht_wa] <= bht_wd;
    if (reset_i && ras_we) ras_q[ras_wa] <= pc_plus4;
  end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit: 16-entry gshare BHT, 2-bit history, 4-deep RAS.
module tb_branch_predict_unit;
  localparam int AB = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  branch_predict_unit_if #(.BP_ADDR_BITS(AB)) bp_if ();

  branch_predict_unit #(
    .BP_ADDR_BITS(AB), .BH_BITS(2), .CTR_BITS(2), .RAS_DEPTH(4), .USE_GSHARE(1)
  ) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bp      (bp_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bp_if.D_valid_i      = 1'b0;
    bp_if.D_stall_i      = 1'b0;
    bp_if.D_flush_i      = 1'b0;
    bp_if.D_PC_i         = 32'h0;
    bp_if.D_isBranch_i   = 1'b0;
    bp_if.D_isJAL_i      = 1'b0;
    bp_if.D_isJALR_i     = 1'b0;
    bp_if.D_rdId_i       = 5'd0;
    bp_if.D_rs1Id_i      = 5'd0;
    bp_if.D_Jimm_i       = 32'h20;
    bp_if.D_Bimm_i       = 32'h40;
    bp_if.E_update_i     = 1'b0;
    bp_if.E_bhtIndex_i   = '0;
    bp_if.E_takeBranch_i = 1'b0;
    bp_if.E_mispredict_i = 1'b0;
  endtask

  task automatic dec(input logic [31:0] pc, input logic br, input logic jal, input logic jalr,
                     input logic [4:0] rd, input logic [4:0] rs1);
    idle();
    bp_if.D_valid_i    = 1'b1;
    bp_if.D_PC_i       = pc;
    bp_if.D_isBranch_i = br;
    bp_if.D_isJAL_i    = jal;
    bp_if.D_isJALR_i   = jalr;
    bp_if.D_rdId_i     = rd;
    bp_if.D_rs1Id_i    = rs1;
  endtask

  task automatic upd(input logic [AB-1:0] idx, input logic tk);
    bp_if.E_update_i     = 1'b1;
    bp_if.E_bhtIndex_i   = idx;
    bp_if.E_takeBranch_i = tk;
  endtask

  logic [31:0] pop_exp [3];

  initial begin
    pop_exp[0] = 32'h404; pop_exp[1] = 32'h304; pop_exp[2] = 32'h204;
    idle();
    repeat (3) tick();
    #1;
    chk("rst_ready", bp_if.ready_o, 0);
    chk("rst_ras_empty", bp_if.D_rasEmpty_o, 1);
    chk("rst_predict_pc", bp_if.D_predictPC_o, 0);
    chk("rst_mcount", bp_if.mispredictCount_o, 0);

    // Sweep interrupted by reset at cycle 7.
    rst_n = 1'b1;
    bp_if.E_mispredict_i = 1'b1;
    tick();
    bp_if.E_mispredict_i = 1'b0;
    repeat (6) tick();
    chk("sweep7_ready", bp_if.ready_o, 0);
    chk("sweep_mcount", bp_if.mispredictCount_o, 1);
    rst_n = 1'b0;
    tick();
    chk("midreset_mcount", bp_if.mispredictCount_o, 0);
    chk("midreset_ready", bp_if.ready_o, 0);

    // Full sweep; updates are ignored, mispredicts are counted.
    rst_n = 1'b1;
    upd(4'd5, 1'b1);
    bp_if.E_mispredict_i = 1'b1;
    tick();
    tick();
    idle();
    repeat (12) tick();
    tick();
    chk("ready_at_15", bp_if.ready_o, 0);
    tick();
    chk("ready_at_16", bp_if.ready_o, 1);
    chk("init_mcount", bp_if.mispredictCount_o, 2);

    // hist=00: PC 0x14 -> idx 5; same-cycle update sees the old counter.
    dec(32'h14, 1, 0, 0, 5'd0, 5'd0);
    upd(4'd5, 1'b1);
    #1;
    chk("init_ctr_pred", bp_if.D_predictBranch_o, 0);
    chk("idx_h00", bp_if.D_bhtIndex_o, 5);
    chk("init_predict_pc", bp_if.D_predictPC_o, 0);
    tick();
    // ctr=10, hist=10: PC 0x34 -> 1101^1000 = 0101.
    dec(32'h34, 1, 0, 0, 5'd0, 5'd0);
    upd(4'd5, 1'b1);
    #1;
    chk("ctr10_pred", bp_if.D_predictBranch_o, 1);
    chk("idx_h10", bp_if.D_bhtIndex_o, 5);
    chk("br_predict_pc", bp_if.D_predictPC_o, 1);
    chk("br_target", bp_if.D_PCprediction_o, 32'h74);
    tick();
    // ctr=11, hist=11: PC 0 -> 1100.
    dec(32'h0, 1, 0, 0, 5'd0, 5'd0);
    upd(4'd5, 1'b1);
    #1;
    chk("gshare_idx", bp_if.D_bhtIndex_o, 4'hC);
    tick();
    // ctr=11 saturated, hist=11: PC 0x24 -> 1001^1100 = 0101.
    dec(32'h24, 1, 0, 0, 5'd0, 5'd0);
    upd(4'd5, 1'b0);
    #1;
    chk("ctr11_pred", bp_if.D_predictBranch_o, 1);
    chk("idx_h11", bp_if.D_bhtIndex_o, 5);
    tick();
    // ctr=10, hist=01: PC 0x4 -> 0001^0100 = 0101.
    dec(32'h4, 1, 0, 0, 5'd0, 5'd0);
    upd(4'd5, 1'b0);
    #1;
    chk("ctr10b_pred", bp_if.D_predictBranch_o, 1);
    chk("idx_h01", bp_if.D_bhtIndex_o, 5);
    tick();
    // ctr=01, hist=00.
    dec(32'h14, 1, 0, 0, 5'd0, 5'd0);
    upd(4'd5, 1'b0);
    #1;
    chk("ctr01_pred", bp_if.D_predictBranch_o, 0);
    tick();
    dec(32'h14, 1, 0, 0, 5'd0, 5'd0);
    upd(4'd5, 1'b0);
    tick();
    // ctr=00 after saturating; one taken moves it to 01, hist=10.
    dec(32'h14, 1, 0, 0, 5'd0, 5'd0);
    #1;
    chk("ctr00_pred", bp_if.D_predictBranch_o, 0);
    upd(4'd5, 1'b1);
    tick();
    dec(32'h34, 1, 0, 0, 5'd0, 5'd0);
    #1;
    chk("ctr00_inc_pred", bp_if.D_predictBranch_o, 0);
    chk("idx_h10b", bp_if.D_bhtIndex_o, 5);

    idle();
    bp_if.E_mispredict_i = 1'b1;
    tick();
    idle();
    #1;
    chk("ready_mcount", bp_if.mispredictCount_o, 3);

    // RAS overflow: five calls, four returns, then empty.
    dec(32'h100, 0, 1, 0, 5'd1, 5'd0);
    bp_if.D_valid_i = 1'b0;
    #1;
    chk("jal_invalid", bp_if.D_predictPC_o, 0);
    bp_if.D_valid_i = 1'b1;
    #1;
    chk("jal_predict_pc", bp_if.D_predictPC_o, 1);
    chk("jal_target", bp_if.D_PCprediction_o, 32'h120);
    chk("ras_empty0", bp_if.D_rasEmpty_o, 1);
    for (int i = 1; i <= 5; i++) begin
      dec(32'(i) * 32'h100, 0, 1, 0, 5'd1, 5'd0);
      tick();
    end
    idle();
    #1;
    chk("ras_top_full", bp_if.D_predictRA_o, 32'h504);
    chk("ras_nonempty", bp_if.D_rasEmpty_o, 0);
    dec(32'h600, 0, 0, 1, 5'd0, 5'd1);
    bp_if.D_stall_i = 1'b1;
    #1;
    chk("stall_pop_target", bp_if.D_PCprediction_o, 32'h504);
    tick();
    bp_if.D_stall_i = 1'b0;
    #1;
    chk("pop0_target", bp_if.D_PCprediction_o, 32'h504);
    chk("pop0_predict_pc", bp_if.D_predictPC_o, 1);
    tick();
    for (int k = 0; k < 3; k++) begin
      dec(32'h600, 0, 0, 1, 5'd0, 5'd1);
      #1;
      chk($sformatf("pop%0d_target", k + 1), bp_if.D_PCprediction_o, pop_exp[k]);
      tick();
    end
    dec(32'h600, 0, 0, 1, 5'd0, 5'd1);
    #1;
    chk("pop4_empty", bp_if.D_rasEmpty_o, 1);
    chk("pop4_predict_pc", bp_if.D_predictPC_o, 0);
    tick();
    idle();
    #1;
    chk("pop_empty_stays", bp_if.D_rasEmpty_o, 1);

    // Pop-then-push.
    dec(32'h100, 0, 1, 0, 5'd1, 5'd0);
    tick();
    dec(32'h300, 0, 0, 1, 5'd5, 5'd1);
    #1;
    chk("pp_target", bp_if.D_PCprediction_o, 32'h104);
    chk("pp_predict_pc", bp_if.D_predictPC_o, 1);
    tick();
    idle();
    #1;
    chk("pp_top", bp_if.D_predictRA_o, 32'h304);
    chk("pp_nonempty", bp_if.D_rasEmpty_o, 0);
    dec(32'h400, 0, 0, 1, 5'd0, 5'd5);
    #1;
    chk("pp_pop_target", bp_if.D_PCprediction_o, 32'h304);
    tick();
    idle();
    #1;
    chk("pp_count_one", bp_if.D_rasEmpty_o, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch/return prediction block that replaces the fixed 2-bit gshare table and 4-entry return address stack embedded in the decode stage. It sits beside decode: decode presents the current instruction's control-flow class and immediates; the block answers combinationally with a next-PC prediction and takes resolution updates from execute. New capabilities:
- configurable counter width, table size and stack depth;
- a bimodal/gshare mode switch;
- an explicit post-reset table-clearing sweep;
- RISC-V link-register hint handling (including pop-then-push);
- a mispredict counter.

## Interface
- BP_ADDR_BITS, 12, BHT index width; BHT_SIZE = 1 << BP_ADDR_BITS
- BH_BITS, 9, global history length; must be ≤ BP_ADDR_BITS
- CTR_BITS, 2, saturating counter width, ≥ 2
- RAS_DEPTH, 4, return stack entries; power of two, ≥ 2
- USE_GSHARE, 1, 1: index = PC bits XOR shifted history; 0: PC bits only
- clk_i  in  1  clock; all state updates on rising edge
- reset_i  in  1  synchronous, active-low reset
- D_valid_i  in  1  decode slot holds a real instruction
- D_stall_i / D_flush_i  in  1  decode stalled / being flushed
- D_PC_i  in  32  decode PC
- D_isBranch_i, D_isJAL_i, D_isJALR_i  in  1  instruction class
- D_rdId_i, D_rs1Id_i  in  5  integer register ids
- D_Jimm_i, D_Bimm_i  in  32  sign-extended immediates
- E_update_i  in  1  resolved conditional branch this cycle (execute not stalled)
- E_bhtIndex_i  in  BP_ADDR_BITS  index carried down from lookup
- E_takeBranch_i  in  1  actual outcome
- E_mispredict_i  in  1  any control-flow mispredict resolved this cycle
- ready_o  out  1  BHT sweep finished
- D_predictPC_o  out  1  redirect fetch to D_PCprediction_o
- D_PCprediction_o  out  32  predicted target
- D_predictBranch_o  out  1  counter MSB at D_bhtIndex_o
- D_bhtIndex_o  out  BP_ADDR_BITS  index to pipeline down
- D_predictRA_o  out  32  current RAS top
- D_rasEmpty_o  out  1  RAS count == 0
- mispredictCount_o  out  32  wrapping mispredict count

## Operation
- Index: PC[BP_ADDR_BITS+1:2], XORed with (hist << (BP_ADDR_BITS-BH_BITS)) when USE_GSHARE=1.
- Init value: 2^(CTR_BITS-1)-1 (weakly not-taken; 01 for 2 bits).
- FSM states:
  - INIT: each cycle write BHT[sweepIdx] = init value, then sweepIdx++. After writing index BHT_SIZE-1, go to READY.
  - READY: normal operation.
- During INIT: ready_o=0, D_predictBranch_o=0, E_update_i ignored, mispredicts still counted.
- Counter update on E_update_i in READY: taken → +1 saturating at 2^CTR_BITS-1; not taken → -1 saturating at 0.
- History update on the same event: hist ← {E_takeBranch_i, hist[BH_BITS-1:1]}.
- Link register = x1 or x5. RAS op when D_valid_i && !D_stall_i && !D_flush_i (independent of ready_o):
  - JAL with rd link: push PC+4.
  - JALR, rd link, rs1 not link: push.
  - JALR, rd not link, rs1 link: pop.
  - JALR, both link, rd≠rs1: pop-then-push (overwrite top with PC+4; tp and count unchanged; count 0 becomes 1).
  - JALR, both link, rd==rs1: push.
- RAS is circular: top pointer tp, count cnt in 0..RAS_DEPTH.
  - Push: tp+1, write entry, cnt saturates at RAS_DEPTH; overflow overwrites the oldest entry.
  - Pop with cnt==0: no state change.
- Prediction:
  - JAL: taken, target PC+Jimm.
  - Branch: taken iff ready_o && counter MSB, target PC+Bimm.
  - JALR: taken iff rs1 is link && cnt>0, target RAS top.
  - D_predictPC_o requires D_valid_i.
- mispredictCount_o increments by 1 on E_mispredict_i and wraps at 2^32.

## Timing
- Lookup outputs are combinational from D_* inputs and current state; zero latency.
- Update and lookup in the same cycle at the same index: lookup returns the pre-update value; the new value is visible the next cycle.
- Push then JALR pop in the next cycle returns the just-pushed address.
- Reset (valid mid-sweep or mid-operation): FSM→INIT, sweepIdx=0, hist=0, tp=0, cnt=0, mispredictCount_o=0.
- Outputs during and after reset: ready_o=0, D_rasEmpty_o=1; D_predictPC_o=0 whenever D_valid_i=0.
- ready_o rises exactly BHT_SIZE cycles after reset deasserts.

## Test plan
- BP_ADDR_BITS=4: release reset → ready_o=1 on cycle 16. Lookup any PC → D_predictBranch_o=0, counter=01.
- Reset asserted at sweep cycle 7 and released → ready_o needs a full 16 more cycles; all entries read 01.
- Three taken updates at index 5 (CTR_BITS=2) → 10, 11, 11 (saturated). Lookup → predictBranch=1. Four not-taken updates → 00.
- RAS_DEPTH=4: JAL x1 at PCs 0x100, 0x200, 0x300, 0x400, 0x500 (overflow); then five `jalr x0,0(x1)`:
  - first four predict 0x504, 0x404, 0x304, 0x204;
  - fifth: D_rasEmpty_o=1, D_predictPC_o=0.
- Push 0x104, then `jalr x5,0(x1)` at 0x300 (pop-then-push) → D_PCprediction_o=0x104 that cycle; next top 0x304, cnt=1.
- USE_GSHARE=1, BH_BITS=2, BP_ADDR_BITS=4: two taken updates → hist=11. PC 0x0 → index 1100b.
